// File: rtl/pe_net_iface.sv
// PE network interface: X/Y hop-header packet builder (TX) and FIFO-buffered unpacker (RX).
// Optional macro NI_PARITY_EN adds even parity on bit 56 (generated on TX, checked on RX).
module pe_net_iface #(
  parameter int MY_X     = 0,
  parameter int MY_Y     = 0,
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [2:0]  tx_dst_x,
  input  logic [1:0]  tx_dst_y,
  input  logic [3:0]  tx_type,
  input  logic [39:0] tx_payload,
  output logic        tx_err,
  output logic [56:0] pkt_out,
  output logic        pkt_out_vld,
  input  logic        pkt_out_rdy,
  input  logic [56:0] pkt_in,
  input  logic        pkt_in_vld,
  output logic        pkt_in_rdy,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [39:0] rx_payload,
  output logic [2:0]  rx_src_x,
  output logic [1:0]  rx_src_y,
  output logic [3:0]  rx_type,
  output logic [7:0]  drop_cnt
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a valid producer holds its data stable until that edge.

  localparam logic [2:0] SELF_X = 3'(MY_X);
  localparam logic [1:0] SELF_Y = 2'(MY_Y);
  localparam int         AW     = $clog2(RX_DEPTH);

  typedef enum logic {IDLE, SEND} tx_state_t;
  tx_state_t state;

  logic        x_dir, y_dir, self_addr, tx_par;
  logic [2:0]  x_hop;
  logic [1:0]  y_hop;
  logic [55:0] tx_body;

  always_comb begin
    x_dir     = tx_dst_x > SELF_X;
    y_dir     = tx_dst_y > SELF_Y;
    x_hop     = x_dir ? (tx_dst_x - SELF_X) : (SELF_X - tx_dst_x);
    y_hop     = y_dir ? (tx_dst_y - SELF_Y) : (SELF_Y - tx_dst_y);
    self_addr = (tx_dst_x == SELF_X) && (tx_dst_y == SELF_Y);
    tx_body   = {tx_type, SELF_Y, SELF_X, x_dir, y_dir, x_hop, y_hop, tx_payload};
`ifdef NI_PARITY_EN
    tx_par    = ^tx_body;
`else
    tx_par    = 1'b0;
`endif
  end

  assign tx_ready    = (state == IDLE);
  assign pkt_out_vld = (state == SEND);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pkt_out <= '0;
      tx_err  <= 1'b0;
    end else begin
      tx_err <= 1'b0;
      case (state)
        IDLE: if (tx_valid) begin
          if (self_addr) begin
            tx_err <= 1'b1;
          end else begin
            pkt_out <= {tx_par, tx_body};
            state   <= SEND;
          end
        end
        SEND: if (pkt_out_rdy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // RX FIFO keeps only the fields the core sees: {type, src_y, src_x, payload}.
  logic [48:0]   mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          in_acc, misrouted, par_bad, push, pop;

  assign pkt_in_rdy = (cnt != (AW+1)'(RX_DEPTH));
  assign rx_valid   = (cnt != '0);
  assign in_acc     = pkt_in_vld & pkt_in_rdy;
  assign misrouted  = |pkt_in[44:40];
`ifdef NI_PARITY_EN
  assign par_bad    = ^pkt_in;
  logic unused_in;
  assign unused_in  = &{1'b0, pkt_in[46:45]};
`else
  assign par_bad    = 1'b0;
  logic unused_in;
  assign unused_in  = &{1'b0, pkt_in[56], pkt_in[46:45]};
`endif
  assign push       = in_acc & ~misrouted & ~par_bad;
  assign pop        = rx_valid & rx_ready;

  assign {rx_type, rx_src_y, rx_src_x, rx_payload} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pkt_in[55:47], pkt_in[39:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (in_acc && !push && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pe_net_iface.sv
// Directed bench for pe_net_iface at node (2,1) with a 4-entry RX FIFO.
module tb_pe_net_iface;
  logic        clk = 1'b0, reset = 1'b1;
  logic        tx_valid = 0, pkt_out_rdy = 0, pkt_in_vld = 0, rx_ready = 0;
  logic [2:0]  tx_dst_x = 0;
  logic [1:0]  tx_dst_y = 0;
  logic [3:0]  tx_type = 0;
  logic [39:0] tx_payload = 0;
  logic [56:0] pkt_in = 0;
  logic        tx_ready, tx_err, pkt_out_vld, pkt_in_rdy, rx_valid;
  logic [56:0] pkt_out;
  logic [39:0] rx_payload;
  logic [2:0]  rx_src_x;
  logic [1:0]  rx_src_y;
  logic [3:0]  rx_type;
  logic [7:0]  drop_cnt;

  int n_cmp = 0, n_err = 0;
  logic [56:0] exp_q[$];
  logic [56:0] e, pa, pb;

  pe_net_iface #(.MY_X(2), .MY_Y(1), .RX_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_dst_x(tx_dst_x), .tx_dst_y(tx_dst_y), .tx_type(tx_type), .tx_payload(tx_payload),
    .tx_err(tx_err), .pkt_out(pkt_out), .pkt_out_vld(pkt_out_vld), .pkt_out_rdy(pkt_out_rdy),
    .pkt_in(pkt_in), .pkt_in_vld(pkt_in_vld), .pkt_in_rdy(pkt_in_rdy),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_payload(rx_payload),
    .rx_src_x(rx_src_x), .rx_src_y(rx_src_y), .rx_type(rx_type), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [56:0] mk(input logic [55:0] body);
`ifdef NI_PARITY_EN
    mk = {^body, body};
`else
    mk = {1'b0, body};
`endif
  endfunction

  // Zero-hop packet as the router would deliver it to this node.
  function automatic logic [56:0] rxp(input logic [3:0] t, input logic [1:0] sy,
                                      input logic [2:0] sx, input logic [39:0] pl);
    rxp = mk({t, sy, sx, 2'b00, 3'd0, 2'd0, pl});
  endfunction

  task automatic check_head(input string tag, input logic [56:0] x);
    check(tag, {rx_type, rx_src_y, rx_src_x, rx_payload}, {x[55:47], x[39:0]});
  endtask

  task automatic request(input logic [2:0] dx, input logic [1:0] dy,
                         input logic [3:0] t, input logic [39:0] pl);
    tx_valid = 1; tx_dst_x = dx; tx_dst_y = dy; tx_type = t; tx_payload = pl;
  endtask

  task automatic drain;
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
      check("rx_valid_drain", rx_valid, 1);
      check_head("rx_head_drain", exp_q[0]);
      rx_ready = 1; tick; rx_ready = 0;
      void'(exp_q.pop_front());
    end
    check("rx_empty_after_drain", rx_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick;
    reset = 0;
    check("rst_tx_ready", tx_ready, 1);
    check("rst_pkt_out_vld", pkt_out_vld, 0);
    check("rst_pkt_out", pkt_out, 0);
    check("rst_tx_err", tx_err, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_pkt_in_rdy", pkt_in_rdy, 1);
    check("rst_drop_cnt", drop_cnt, 0);

    // East/north: xhop 3, yhop 2, valid one cycle after accept.
    request(3'd5, 2'd3, 4'h3, 40'hA5);
    check("t1_vld_before", pkt_out_vld, 0);
    tick; tx_valid = 0;
    e = mk({4'h3, 2'd1, 3'd2, 1'b1, 1'b1, 3'd3, 2'd2, 40'hA5});
    check("t1_vld", pkt_out_vld, 1);
    check("t1_pkt", pkt_out, e);
    check("t1_tx_ready", tx_ready, 0);
    pkt_out_rdy = 1; tick; pkt_out_rdy = 0;
    check("t1_vld_done", pkt_out_vld, 0);
    check("t1_ready_back", tx_ready, 1);

    // West/south with router backpressure; a pending request must not disturb pkt_out.
    request(3'd0, 2'd0, 4'hC, 40'h12_3456_789A);
    tick;
    request(3'd7, 2'd2, 4'h9, 40'hFF_FFFF_FFFF);
    e = mk({4'hC, 2'd1, 3'd2, 1'b0, 1'b0, 3'd2, 2'd1, 40'h12_3456_789A});
    for (int i = 0; i < 5; i++) begin
      check("t2_pkt_stable", pkt_out, e);
      check("t2_vld_held", pkt_out_vld, 1);
      check("t2_tx_ready", tx_ready, 0);
      tick;
    end
    tx_valid = 0; pkt_out_rdy = 1; tick; pkt_out_rdy = 0;
    check("t2_vld_done", pkt_out_vld, 0);

    // Self-addressed request is dropped with a one-cycle error pulse.
    request(3'd2, 2'd1, 4'h1, 40'h55);
    tick;
    request(3'd3, 2'd1, 4'h6, 40'h77);
    check("t3_tx_err", tx_err, 1);
    check("t3_no_vld", pkt_out_vld, 0);
    check("t3_ready", tx_ready, 1);
    tick; tx_valid = 0;
    check("t3_err_cleared", tx_err, 0);
    check("t3_next_vld", pkt_out_vld, 1);
    check("t3_next_pkt", pkt_out, mk({4'h6, 2'd1, 3'd2, 1'b1, 1'b0, 3'd1, 2'd0, 40'h77}));
    pkt_out_rdy = 1; tick; pkt_out_rdy = 0;

    // Fill the FIFO, attempt a fifth push, then pop one and drain in order.
    for (int i = 0; i < 4; i++) begin
      e = rxp(4'(i + 1), 2'(i), 3'(i + 4), 40'h100 + 40'(i));
      pkt_in = e; pkt_in_vld = 1; tick;
      exp_q.push_back(e);
    end
    check("t4_full_rdy", pkt_in_rdy, 0);
    pkt_in = rxp(4'hF, 2'd3, 3'd7, 40'hDEAD);
    tick; pkt_in_vld = 0;
    check("t4_full_hold_rdy", pkt_in_rdy, 0);
    check("t4_no_drop", drop_cnt, 0);
    check_head("t4_head0", exp_q[0]);
    rx_ready = 1; tick; rx_ready = 0;
    void'(exp_q.pop_front());
    check("t4_rdy_after_pop", pkt_in_rdy, 1);
    drain;

    // Simultaneous push and pop.
    pa = rxp(4'h2, 2'd2, 3'd6, 40'hAAAA);
    pb = rxp(4'h5, 2'd0, 3'd1, 40'hBBBB);
    pkt_in = pa; pkt_in_vld = 1; tick;
    pkt_in = pb; rx_ready = 1;
    check_head("t5_head_a", pa);
    tick; pkt_in_vld = 0; rx_ready = 0;
    exp_q.push_back(pb);
    check("t5_rdy", pkt_in_rdy, 1);
    drain;

    // Misrouted packet (xhop=1) is consumed and counted.
    pkt_in = mk({4'h3, 2'd0, 3'd0, 2'b00, 3'd1, 2'd0, 40'h42}); pkt_in_vld = 1; tick; pkt_in_vld = 0;
    check("t6_misroute_rx", rx_valid, 0);
    check("t6_drop1", drop_cnt, 1);
`ifdef NI_PARITY_EN
    pkt_in = rxp(4'h3, 2'd0, 3'd0, 40'h42) ^ (57'd1 << 7); pkt_in_vld = 1; tick; pkt_in_vld = 0;
    check("t6_par_rx", rx_valid, 0);
    check("t6_drop2", drop_cnt, 2);
`else
    e = rxp(4'h3, 2'd0, 3'd0, 40'h42) ^ (57'd1 << 56);
    pkt_in = e; pkt_in_vld = 1; tick; pkt_in_vld = 0;
    exp_q.push_back(e);
    check("t6_bit56_ignored", drop_cnt, 1);
    drain;
`endif

    // Saturation of drop_cnt.
    pkt_in = mk({4'h0, 2'd0, 3'd0, 2'b00, 3'd0, 2'd2, 40'h0}); pkt_in_vld = 1;
    repeat (260) tick;
    pkt_in_vld = 0;
    check("t7_drop_sat", drop_cnt, 8'hFF);
    check("t7_rx_empty", rx_valid, 0);

    // Reset while in SEND with two packets buffered.
    for (int i = 0; i < 2; i++) begin
      pkt_in = rxp(4'h7, 2'd1, 3'd3, 40'h900 + 40'(i)); pkt_in_vld = 1; tick;
    end
    pkt_in_vld = 0;
    request(3'd5, 2'd3, 4'h3, 40'hA5);
    tick; tx_valid = 0;
    check("t8_pre_vld", pkt_out_vld, 1);
    check("t8_pre_rx", rx_valid, 1);
    reset = 1; tick; reset = 0;
    check("t8_vld", pkt_out_vld, 0);
    check("t8_pkt_out", pkt_out, 0);
    check("t8_rx_valid", rx_valid, 0);
    check("t8_drop", drop_cnt, 0);
    check("t8_rdy", pkt_in_rdy, 1);
    check("t8_tx_ready", tx_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
